// File: rtl/riffa_chnl_pkg.sv
// Shared encodings and helpers for the RIFFA RX channel to AXI4-Stream bridge.
package riffa_chnl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_DATA     = 2'd2,
        ST_WAIT_END = 2'd3
    } rx_state_e;

    function automatic int words_per_beat(input int data_width);
        return data_width / 32'sd32;
    endfunction

    // A byte is kept when it falls inside the words still owed by the transaction.
    function automatic logic byte_kept(input logic [31:0] rem, input int words, input int byte_idx);
        if (rem >= 32'(words)) begin
            return 1'b1;
        end else begin
            return (32'(byte_idx) < {rem[29:0], 2'b00});
        end
    endfunction

endpackage

// File: rtl/riffa_skid_fifo2.sv
// Two-entry valid/ready FIFO; entry 0 is always the head presented downstream.
module riffa_skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem0_r;
    logic [WIDTH-1:0] mem1_r;
    logic [1:0]       count_r;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign out_data  = mem0_r;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Storage and occupancy; simultaneous push/pop only occurs with one entry held.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_r  <= {WIDTH{1'b0}};
            mem1_r  <= {WIDTH{1'b0}};
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        mem0_r <= in_data;
                    end else begin
                        mem1_r <= in_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    mem0_r  <= mem1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    mem0_r <= in_data;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/riffa_rx_axis_bridge.sv
// RIFFA RX data channel to AXI4-Stream master: handshake, word counting, TKEEP/TLAST
// generation, with a 2-entry buffer so stream backpressure throttles RIFFA via REN.
module riffa_rx_axis_bridge
    import riffa_chnl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    output logic                          CHNL_DATA_RX_CLK,
    input  logic                          CHNL_DATA_RX,
    output logic                          CHNL_DATA_RX_ACK,
    input  logic                          CHNL_DATA_RX_LAST,
    input  logic [31:0]                   CHNL_DATA_RX_LEN,
    input  logic [30:0]                   CHNL_DATA_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0]   CHNL_DATA_RX_DATA,
    input  logic                          CHNL_DATA_RX_DATA_VALID,
    output logic                          CHNL_DATA_RX_DATA_REN,
    output logic [C_PCI_DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_PCI_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic [30:0]                   RX_OFF,
    output logic                          RX_LAST,
    output logic                          RX_BUSY,
    output logic                          RX_DONE
);

    localparam int          C_WORDS   = words_per_beat(C_PCI_DATA_WIDTH);
    localparam int          C_KEEP_W  = C_PCI_DATA_WIDTH / 8;
    localparam int          C_ENTRY_W = C_PCI_DATA_WIDTH + C_KEEP_W + 1;
    localparam logic [31:0] C_WORDS_U = 32'(C_WORDS);

    rx_state_e             state_r;
    logic [31:0]           rem_r;
    logic [30:0]           off_r;
    logic                  last_r;
    logic                  ack_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  ren_s;
    logic                  beat_take_s;
    logic                  last_beat_s;
    logic [31:0]           rem_step_s;
    logic [C_KEEP_W-1:0]   keep_s;
    logic [C_ENTRY_W-1:0]  push_data_s;
    logic [C_ENTRY_W-1:0]  head_s;
    logic                  fifo_ready_s;
    logic                  fifo_valid_s;

    assign CHNL_DATA_RX_CLK = CLK;

    // REN depends only on state and buffer occupancy, never on VALID.
    assign ren_s       = (state_r == ST_DATA) && fifo_ready_s;
    assign beat_take_s = ren_s && CHNL_DATA_RX_DATA_VALID;
    assign last_beat_s = (rem_r <= C_WORDS_U);
    assign rem_step_s  = last_beat_s ? rem_r : C_WORDS_U;

    // Byte enables for the beat at the head of the input: partial only on the last beat.
    always_comb begin
        keep_s = {C_KEEP_W{1'b0}};
        for (int i = 0; i < C_KEEP_W; i++) begin
            keep_s[i] = byte_kept(rem_r, C_WORDS, i);
        end
    end

    assign push_data_s = {CHNL_DATA_RX_DATA, keep_s, last_beat_s};

    riffa_skid_fifo2 #(
        .WIDTH (C_ENTRY_W)
    ) u_buf (
        .clk       (CLK),
        .rst       (RST),
        .in_data   (push_data_s),
        .in_valid  (beat_take_s),
        .in_ready  (fifo_ready_s),
        .out_data  (head_s),
        .out_valid (fifo_valid_s),
        .out_ready (M_AXIS_TREADY)
    );

    assign M_AXIS_TDATA          = head_s[C_ENTRY_W-1 -: C_PCI_DATA_WIDTH];
    assign M_AXIS_TKEEP          = head_s[C_KEEP_W:1];
    assign M_AXIS_TLAST          = head_s[0];
    assign M_AXIS_TVALID         = fifo_valid_s;
    assign CHNL_DATA_RX_DATA_REN = ren_s;
    assign CHNL_DATA_RX_ACK      = ack_r;
    assign RX_OFF                = off_r;
    assign RX_LAST               = last_r;
    assign RX_BUSY               = busy_r;
    assign RX_DONE               = done_r;

    // Transaction FSM with registered ACK/BUSY/DONE and latched request fields.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            rem_r   <= 32'd0;
            off_r   <= 31'd0;
            last_r  <= 1'b0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ack_r  <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (CHNL_DATA_RX) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                ST_ACK: begin
                    rem_r   <= CHNL_DATA_RX_LEN;
                    off_r   <= CHNL_DATA_RX_OFF;
                    last_r  <= CHNL_DATA_RX_LAST;
                    state_r <= (CHNL_DATA_RX_LEN != 32'd0) ? ST_DATA : ST_WAIT_END;
                end
                ST_DATA: begin
                    if (beat_take_s) begin
                        rem_r <= rem_r - rem_step_s;
                        if (last_beat_s) begin
                            state_r <= ST_WAIT_END;
                        end
                    end
                end
                ST_WAIT_END: begin
                    // Empty buffer implies the TLAST beat has already left.
                    if (!fifo_valid_s && !CHNL_DATA_RX) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riffa_rx_axis_bridge.sv
// Randomized self-checking bench for riffa_rx_axis_bridge at 64-bit data width.
module tb_riffa_rx_axis_bridge;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CHNL_DATA_RX_CLK;
    logic        CHNL_DATA_RX = 1'b0;
    logic        CHNL_DATA_RX_ACK;
    logic        CHNL_DATA_RX_LAST = 1'b0;
    logic [31:0] CHNL_DATA_RX_LEN = 32'd0;
    logic [30:0] CHNL_DATA_RX_OFF = 31'd0;
    logic [63:0] CHNL_DATA_RX_DATA = 64'd0;
    logic        CHNL_DATA_RX_DATA_VALID = 1'b0;
    logic        CHNL_DATA_RX_DATA_REN;
    logic [63:0] M_AXIS_TDATA;
    logic [7:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b0;
    logic [30:0] RX_OFF;
    logic        RX_LAST;
    logic        RX_BUSY;
    logic        RX_DONE;

    int checks = 0;
    int failures = 0;

    int r_beats, r_ack, r_ack_c, r_done, r_acc0, r_tv0, r_tvn, r_ren_full;

    riffa_rx_axis_bridge #(.C_PCI_DATA_WIDTH(64)) dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .CHNL_DATA_RX_CLK        (CHNL_DATA_RX_CLK),
        .CHNL_DATA_RX            (CHNL_DATA_RX),
        .CHNL_DATA_RX_ACK        (CHNL_DATA_RX_ACK),
        .CHNL_DATA_RX_LAST       (CHNL_DATA_RX_LAST),
        .CHNL_DATA_RX_LEN        (CHNL_DATA_RX_LEN),
        .CHNL_DATA_RX_OFF        (CHNL_DATA_RX_OFF),
        .CHNL_DATA_RX_DATA       (CHNL_DATA_RX_DATA),
        .CHNL_DATA_RX_DATA_VALID (CHNL_DATA_RX_DATA_VALID),
        .CHNL_DATA_RX_DATA_REN   (CHNL_DATA_RX_DATA_REN),
        .M_AXIS_TDATA            (M_AXIS_TDATA),
        .M_AXIS_TKEEP            (M_AXIS_TKEEP),
        .M_AXIS_TLAST            (M_AXIS_TLAST),
        .M_AXIS_TVALID           (M_AXIS_TVALID),
        .M_AXIS_TREADY           (M_AXIS_TREADY),
        .RX_OFF                  (RX_OFF),
        .RX_LAST                 (RX_LAST),
        .RX_BUSY                 (RX_BUSY),
        .RX_DONE                 (RX_DONE)
    );

    always #5 CLK = ~CLK;

    // Drives one full transaction and scoreboards every AXIS beat against a word-level model.
    // rmode: 0 ready always, 1 ready 1-on/2-off, 2 random. vmode: 0 continuous, 1 random gaps.
    task automatic run_txn(input int len, input logic [30:0] off, input logic lst,
                           input int rmode, input int vmode, input bit drop_early);
        logic [63:0] in_q[$];
        beat_t       exp_q[$];
        beat_t       exp_b, got_b, prev_b;
        bit          stall_prev, seen_ack;
        int          nb, bi, c, done_c, left;
        logic [31:0] lo, hi;
        stall_prev = 1'b0;
        seen_ack   = 1'b0;
        prev_b     = '0;
        nb = (len + 1) / 2;
        for (int k = 0; k < nb; k++) begin
            lo   = $urandom;
            hi   = $urandom;
            left = len - 2 * k;
            in_q.push_back({hi, lo});
            exp_b.d = {hi, lo};
            exp_b.k = (left >= 2) ? 8'hFF : 8'h0F;
            exp_b.l = (k == nb - 1);
            exp_q.push_back(exp_b);
        end
        r_beats = 0; r_ack = 0; r_ack_c = -1; r_done = 0;
        r_acc0 = -1; r_tv0 = -1; r_tvn = -1; r_ren_full = 0;
        bi = 0; c = 0; done_c = -1;
        @(negedge CLK);
        CHNL_DATA_RX      = 1'b1;
        CHNL_DATA_RX_LEN  = 32'(len);
        CHNL_DATA_RX_OFF  = off;
        CHNL_DATA_RX_LAST = lst;
        while (c < 3000) begin
            if (c > 0) @(negedge CLK);
            if (CHNL_DATA_RX_ACK) begin
                r_ack++;
                if (r_ack_c < 0) r_ack_c = c;
                seen_ack = 1'b1;
            end
            if (RX_DONE) begin
                r_done++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
            if (seen_ack && (drop_early || bi >= nb)) CHNL_DATA_RX = 1'b0;
            case (rmode)
                1: M_AXIS_TREADY = (c % 3 == 0);
                2: M_AXIS_TREADY = 1'($urandom_range(0, 1));
                default: M_AXIS_TREADY = 1'b1;
            endcase
            if (seen_ack && bi < nb && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
                CHNL_DATA_RX_DATA_VALID = 1'b1;
                CHNL_DATA_RX_DATA       = in_q[bi];
            end else begin
                CHNL_DATA_RX_DATA_VALID = 1'b0;
                CHNL_DATA_RX_DATA       = {$urandom, $urandom};
            end
            #1;
            got_b = {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST};
            if (stall_prev) begin
                checks++;
                if (M_AXIS_TVALID !== 1'b1 || got_b !== prev_b) begin
                    failures++;
                    $display("FAIL hold_stable c=%0d got valid=%b beat=%h want valid=1 beat=%h",
                             c, M_AXIS_TVALID, got_b, prev_b);
                end
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat c=%0d got beat=%h want no beat", c, got_b);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got_b !== exp_b) begin
                        failures++;
                        $display("FAIL beat_data c=%0d got %h want %h", c, got_b, exp_b);
                    end
                end
                r_beats++;
                if (r_tv0 < 0) r_tv0 = c;
                r_tvn = c;
            end
            stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_b     = got_b;
            if (c >= 2 && seen_ack && bi < nb && !CHNL_DATA_RX_DATA_REN) r_ren_full++;
            if (CHNL_DATA_RX_DATA_VALID && CHNL_DATA_RX_DATA_REN) begin
                if (r_acc0 < 0) r_acc0 = c;
                bi++;
            end
            c++;
        end
        CHNL_DATA_RX            = 1'b0;
        CHNL_DATA_RX_DATA_VALID = 1'b0;
        checks++;
        if (done_c < 0) begin
            failures++;
            $display("FAIL done_timeout got no RX_DONE want pulse len=%0d", len);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_beats got %0d unsent want 0", exp_q.size());
        end
        checks++;
        if (RX_BUSY !== 1'b0 || M_AXIS_TVALID !== 1'b0) begin
            failures++;
            $display("FAIL idle_after got busy=%b tvalid=%b want 0 0", RX_BUSY, M_AXIS_TVALID);
        end
        checks++;
        if (r_ack != 1 || r_done != 1 || r_ack_c != 1) begin
            failures++;
            $display("FAIL handshake got ack=%0d ack_c=%0d done=%0d want 1 1 1", r_ack, r_ack_c, r_done);
        end
        checks++;
        if (RX_OFF !== off || RX_LAST !== lst) begin
            failures++;
            $display("FAIL latched got off=%h last=%b want off=%h last=%b", RX_OFF, RX_LAST, off, lst);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} !== 74'd0) begin
            failures++;
            $display("FAIL reset_axis got valid=%b last=%b keep=%h data=%h want all 0",
                     M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA);
        end
        checks++;
        if ({CHNL_DATA_RX_ACK, CHNL_DATA_RX_DATA_REN, RX_BUSY, RX_DONE, RX_LAST, RX_OFF} !== 36'd0) begin
            failures++;
            $display("FAIL reset_ctrl got ack=%b ren=%b busy=%b done=%b last=%b off=%h want all 0",
                     CHNL_DATA_RX_ACK, CHNL_DATA_RX_DATA_REN, RX_BUSY, RX_DONE, RX_LAST, RX_OFF);
        end
        checks++;
        if (CHNL_DATA_RX_CLK !== CLK) begin
            failures++;
            $display("FAIL rx_clk got %b want %b", CHNL_DATA_RX_CLK, CLK);
        end
        RST = 1'b0;
    endtask

    task automatic test_len8_streaming();
        run_txn(8, 31'h5, 1'b0, 0, 0, 1'b0);
        checks++;
        if (r_beats != 4) begin
            failures++;
            $display("FAIL len8_beats got %0d want 4", r_beats);
        end
        checks++;
        if (r_acc0 != 2 || r_tv0 - r_acc0 != 1) begin
            failures++;
            $display("FAIL len8_latency got acc=%0d tv=%0d want acc=2 tv=3", r_acc0, r_tv0);
        end
        checks++;
        if (r_tvn - r_tv0 != 3 || r_ren_full != 0) begin
            failures++;
            $display("FAIL len8_throughput got span=%0d ren_low=%0d want 3 0", r_tvn - r_tv0, r_ren_full);
        end
    endtask

    task automatic test_len5_partial();
        run_txn(5, 31'h7ABC, 1'b1, 0, 0, 1'b0);
        checks++;
        if (r_beats != 3) begin
            failures++;
            $display("FAIL len5_beats got %0d want 3", r_beats);
        end
    endtask

    task automatic test_backpressure();
        run_txn(16, 31'h1, 1'b0, 1, 0, 1'b0);
        checks++;
        if (r_beats != 8) begin
            failures++;
            $display("FAIL bp_beats got %0d want 8", r_beats);
        end
        checks++;
        if (r_ren_full == 0) begin
            failures++;
            $display("FAIL bp_ren_drop got %0d low cycles want >0", r_ren_full);
        end
    endtask

    task automatic test_len0();
        run_txn(0, 31'h44, 1'b1, 0, 0, 1'b0);
        checks++;
        if (r_beats != 0) begin
            failures++;
            $display("FAIL len0_beats got %0d want 0", r_beats);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(int'($urandom_range(1, 9)), 31'h10, 1'b0, 2, 1, 1'b0);
        run_txn(int'($urandom_range(1, 9)), 31'h20, 1'b1, 2, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int acc;
        bit got_ack;
        acc = 0;
        got_ack = 1'b0;
        @(negedge CLK);
        M_AXIS_TREADY     = 1'b0;
        CHNL_DATA_RX      = 1'b1;
        CHNL_DATA_RX_LEN  = 32'd16;
        CHNL_DATA_RX_OFF  = 31'h33;
        CHNL_DATA_RX_LAST = 1'b0;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            @(negedge CLK);
            if (CHNL_DATA_RX_ACK) got_ack = 1'b1;
        end
        checks++;
        if (!got_ack) begin
            failures++;
            $display("FAIL rstmid_ack got no ACK want ACK");
        end
        for (int i = 0; i < 6; i++) begin
            CHNL_DATA_RX_DATA_VALID = 1'b1;
            CHNL_DATA_RX_DATA       = {$urandom, $urandom};
            #1;
            if (CHNL_DATA_RX_DATA_REN) acc++;
            @(negedge CLK);
        end
        checks++;
        if (acc != 2 || M_AXIS_TVALID !== 1'b1 || CHNL_DATA_RX_DATA_REN !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_full got acc=%0d tvalid=%b ren=%b want 2 1 0",
                     acc, M_AXIS_TVALID, CHNL_DATA_RX_DATA_REN);
        end
        RST = 1'b1;
        CHNL_DATA_RX = 1'b0;
        CHNL_DATA_RX_DATA_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST, CHNL_DATA_RX_DATA_REN, CHNL_DATA_RX_ACK, RX_BUSY} !== 5'd0) begin
            failures++;
            $display("FAIL rstmid_flush got tvalid=%b tlast=%b ren=%b ack=%b busy=%b want 0",
                     M_AXIS_TVALID, M_AXIS_TLAST, CHNL_DATA_RX_DATA_REN, CHNL_DATA_RX_ACK, RX_BUSY);
        end
        RST = 1'b0;
        run_txn(6, 31'h55, 1'b1, 0, 0, 1'b0);
        checks++;
        if (r_beats != 3) begin
            failures++;
            $display("FAIL rstmid_recover got %0d beats want 3", r_beats);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            run_txn(int'($urandom_range(1, 13)), 31'($urandom), 1'($urandom_range(0, 1)),
                    2, 1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_len8_streaming();
        test_len5_partial();
        test_backpressure();
        test_len0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
